cntr4m_seq: RTL and testbench
=============================

Name: cntr4m_seq

Overview:
- Command sequencer that drives the 4-mode 8-bit counter interface (m, Ci, B in; Q, Co out) from the initiator side.
- Takes a job: preload value, direction and step count. Loads the counter, issues exactly that many count enables, then checks the final Q against the expected value.
- Reports completion, wrap-around and mismatch.
- Sits between the control datapath and a Counter8bit_4m_1 instance.

Parameters:
- WIDTH, 8, width of the counter value, preload, step count and B/Q buses.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- dir  input  1  0 = count up, 1 = count down; captured on start.
- preload  input  WIDTH  initial counter value; captured on start.
- steps  input  WIDTH  number of count enables to issue; captured on start.
- pause  input  1  while high in RUN, the counter holds and no step is consumed.
- Q  input  WIDTH  counter value from the counter.
- Co  input  1  counter carry/borrow out.
- m  output  2  counter mode: 00 hold, 01 up, 10 down, 11 load B.
- Ci  output  1  counter count enable.
- B  output  WIDTH  counter load value.
- busy  output  1  high from the cycle after an accepted start until the return to IDLE.
- done  output  1  one-cycle pulse in CHECK.
- wrap  output  1  sticky; a Co was sampled during the job.
- err  output  1  sticky; final Q differed from the expected value.

Behaviour:
- Counter contract:
  - The counter updates on the clk edge from m/Ci/B.
  - m=11 loads B.
  - m=01/10 with Ci=1 increments/decrements modulo 2^WIDTH.
  - Co is asserted in the cycle where Ci=1 and Q is the terminal value: all-ones for up, zero for down.
- Reset (async, rst=0):
  - state=IDLE; m=00, Ci=0, B=0, busy=0, done=0, wrap=0, err=0.
  - Internal registers cleared.
  - Takes effect immediately, including mid-job; the partially counted Q is abandoned.
- States: IDLE, LOAD, RUN, CHECK.
- IDLE:
  - m=00, Ci=0.
  - start=1 captures dir, preload and steps into registers; rem<=steps; exp<=preload+steps (up) or preload-steps (down), mod 2^WIDTH.
  - Clears wrap and err; goes to LOAD.
- LOAD (exactly 1 cycle):
  - m=11, B=captured preload, Ci=0, busy=1.
  - Next state is RUN if rem!=0, CHECK if rem==0.
- RUN:
  - m = dir ? 10 : 01.
  - Ci = ~pause, combinational from pause.
  - On each edge with Ci=1: rem<=rem-1; if Co=1, wrap<=1.
  - Goes to CHECK on the edge where Ci=1 and rem==1.
  - pause=1 holds rem and state indefinitely.
  - The number of Ci=1 cycles in RUN equals the captured steps exactly.
- CHECK (exactly 1 cycle):
  - m=00, Ci=0, done=1.
  - Q now reflects the last step.
  - If Q!=exp, err<=1.
  - Returns to IDLE; busy falls in that same transition.
- B holds the captured preload until the next start.
- start while not in IDLE is ignored; no queueing.
- start held high continuously restarts a new job on the first IDLE cycle after CHECK.
- Captured inputs are unaffected by changes to dir/preload/steps during a job.
- wrap and err stay valid until the next accepted start or reset.
- Latency from start to done: steps+2 cycles, plus one cycle per paused cycle in RUN.

Test Plan:
- Up count: preload=0x17, steps=5, dir=0, pause=0.
  - Required: m=11 for 1 cycle with B=0x17, then m=01/Ci=1 for 5 cycles.
  - Required: done on cycle 7 after start, Q=0x1C, wrap=0, err=0.
- Down wrap: preload=0x02, steps=4, dir=1.
  - Required: Co seen when Q=0x00, Q=0xFE at done, wrap=1, err=0.
- Zero steps: preload=0xB1, steps=0.
  - Required: LOAD then CHECK; no Ci pulse; done 2 cycles after start; Q=0xB1, err=0.
- Pause: preload=0x00, steps=3, pause high for 4 cycles mid-RUN.
  - Required: exactly 3 Ci=1 cycles; done after 9 cycles; Q=0x03.
- Mismatch: force the counter Q to be held at the CHECK cycle (m tap overridden).
  - Required: err=1 on the done pulse, err stays 1 until the next start.
- Reset mid-job: rst=0 during RUN with rem=2.
  - Required: immediately m=00, Ci=0, busy=0, done=0.
  - Required: start after release runs a fresh job correctly.

Source files
------------

// File: rtl/cntr4m_seq.sv
// cntr4m_seq: initiator-side sequencer for a 4-mode counter.
// Loads a preload value, issues an exact number of count enables, then checks Q.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start    job request, accepted only in IDLE
//   dir      0 = count up, 1 = count down (captured on start)
//   preload  initial counter value (captured on start)
//   steps    number of count enables to issue (captured on start)
//   pause    in RUN: hold the counter, consume no step
//   Q, Co    counter value and carry/borrow out
//   m        counter mode: 00 hold, 01 up, 10 down, 11 load B
//   Ci       counter count enable
//   B        counter load value (captured preload)
//   busy     high from the cycle after an accepted start until back in IDLE
//   done     one-cycle pulse in CHECK
//   wrap     sticky: Co was seen on a counted step of this job
//   err      sticky: final Q differed from the expected value
module cntr4m_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] preload,
    input  logic [WIDTH-1:0] steps,
    input  logic             pause,
    input  logic [WIDTH-1:0] Q,
    input  logic             Co,
    output logic [1:0]       m,
    output logic             Ci,
    output logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DN   = 2'b10;
    localparam logic [1:0] M_LD   = 2'b11;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10,
        CHECK = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             dir_q;
    logic [WIDTH-1:0] pre_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] exp_q;
    logic             wrap_q;
    logic             err_q;

    logic             accept;
    logic             step;
    logic             mismatch;
    logic [WIDTH-1:0] exp_d;

    // Final value the counter must reach, modulo 2^WIDTH.
    always_comb begin
        exp_d = dir ? (preload - steps) : (preload + steps);
    end

    // Next-state and counter-side outputs.
    always_comb begin
        state_d  = state_q;
        m        = M_HOLD;
        Ci       = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        mismatch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                m       = M_LD;
                state_d = (rem_q == ZERO) ? CHECK : RUN;
            end
            RUN: begin
                m    = dir_q ? M_DN : M_UP;
                Ci   = ~pause;
                step = ~pause;
                if (step && (rem_q == ONE)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done     = 1'b1;
                mismatch = (Q != exp_q);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q  <= 1'b0;
            pre_q  <= '0;
            rem_q  <= '0;
            exp_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                dir_q  <= dir;
                pre_q  <= preload;
                rem_q  <= steps;
                exp_q  <= exp_d;
                wrap_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (step) begin
                rem_q <= rem_q - ONE;
                if (Co) begin
                    wrap_q <= 1'b1;
                end
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign B    = pre_q;
    assign busy = (state_q != IDLE);
    assign wrap = wrap_q;
    // The compare result is visible on the done pulse itself, then held.
    assign err  = err_q | mismatch;

endmodule

// File: tb/tb_cntr4m_seq.sv
// tb_cntr4m_seq: scoreboard bench for cntr4m_seq with a behavioural counter.
// Expected job results are queued at start and compared on each done pulse.
module tb_cntr4m_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [7:0] preload;
    logic [7:0] steps;
    logic       pause;
    logic [7:0] cq = 8'h00;
    logic       co;
    logic [1:0] m;
    logic       Ci;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    bit         freeze = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         ndone  = 0;

    typedef struct {
        logic [7:0] pre;
        logic [7:0] q;
        logic       w;
        logic       e;
        int         lat;
        int         st;
    } exp_t;

    exp_t sb[$];

    cntr4m_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .preload (preload),
        .steps   (steps),
        .pause   (pause),
        .Q       (cq),
        .Co      (co),
        .m       (m),
        .Ci      (Ci),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Counter model; freeze makes it ignore count enables (forced mismatch).
    always @(posedge clk) begin
        if (m == 2'b11) begin
            cq <= B;
        end else if (Ci && !freeze) begin
            if (m == 2'b01) cq <= cq + 8'd1;
            else if (m == 2'b10) cq <= cq - 8'd1;
        end
    end

    assign co = Ci && (((m == 2'b01) && (cq == 8'hFF)) ||
                       ((m == 2'b10) && (cq == 8'h00)));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [7:0] pre, input logic [7:0] st,
                                   input logic d, input bit frz, input int plen);
        exp_t       e;
        logic [7:0] q;
        logic [7:0] tgt;
        q   = pre;
        e.w = 1'b0;
        for (int i = 0; i < int'(st); i++) begin
            if (d ? (q == 8'h00) : (q == 8'hFF)) e.w = 1'b1;
            if (!frz) q = d ? q - 8'd1 : q + 8'd1;
        end
        tgt   = d ? pre - st : pre + st;
        e.pre = pre;
        e.q   = q;
        e.e   = (q != tgt);
        e.lat = int'(st) + 2 + plen;
        e.st  = int'(st);
        return e;
    endfunction

    // Monitor: per-job cycle, Ci and load counts; compare on done.
    bit   bd   = 1'b0;
    int   k    = 0;
    int   nci  = 0;
    int   nld  = 0;
    exp_t got_e;

    initial begin
        forever begin
            @(negedge clk);
            if (busy && !bd) begin
                k   = 0;
                nci = 0;
                nld = 0;
                chk("wrap_clr", wrap, 0);
                chk("err_clr", err, 0);
            end
            if (busy) k++;
            if (busy && (m == 2'b11)) begin
                nld++;
                if (sb.size() > 0) chk("load_b", B, sb[0].pre);
            end
            if (Ci) nci++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexp_done", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    chk("q", cq, got_e.q);
                    chk("wrap", wrap, got_e.w);
                    chk("err", err, got_e.e);
                    chk("latency", k, got_e.lat);
                    chk("ci_count", nci, got_e.st);
                    chk("load_count", nld, 1);
                end
                ndone++;
            end
            bd = busy;
        end
    end

    task automatic run_job(input logic [7:0] pre, input logic [7:0] st,
                           input logic d, input int p_at, input int p_len,
                           input bit frz);
        int cyc;
        int n0;
        sb.push_back(model(pre, st, d, frz, p_len));
        @(posedge clk);
        #1;
        freeze  = frz;
        start   = 1'b1;
        dir     = d;
        preload = pre;
        steps   = st;
        @(posedge clk);
        #1;
        start   = 1'b0;
        dir     = ~d;
        preload = 8'h5A;
        steps   = 8'h03;
        n0  = ndone;
        cyc = 1;
        while ((ndone == n0) && (cyc < 400)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                start   = 1'b1;
                preload = 8'h55;
            end
            if (cyc == 3) start = 1'b0;
            if (cyc == p_at) pause = 1'b1;
            if (cyc == p_at + p_len) pause = 1'b0;
        end
        if (ndone == n0) chk("timeout", 0, 1);
        start  = 1'b0;
        pause  = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        preload = 8'h00;
        steps   = 8'h00;
        pause   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m", m, 0);
        chk("rst_ci", Ci, 0);
        chk("rst_b", B, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        run_job(8'h17, 8'd5, 1'b0, -1, 0, 1'b0);
        run_job(8'h02, 8'd4, 1'b1, -1, 0, 1'b0);
        run_job(8'hB1, 8'd0, 1'b0, -1, 0, 1'b0);
        run_job(8'h00, 8'd3, 1'b0, 3, 4, 1'b0);
        run_job(8'h10, 8'd2, 1'b0, -1, 0, 1'b1);
        chk("err_sticky0", err, 1);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky3", err, 1);

        // Reset in RUN with two steps still outstanding.
        sb.push_back(model(8'h40, 8'd5, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        start   = 1'b1;
        dir     = 1'b0;
        preload = 8'h40;
        steps   = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_m", m, 0);
        chk("mid_rst_ci", Ci, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;

        run_job(8'hF0, 8'h20, 1'b0, -1, 0, 1'b0);
        run_job(8'h05, 8'hFF, 1'b1, -1, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
